// File: rtl/infra_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package infra_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } seq_state_e;

    // Counter width for a count of n cycles (values 0..n-1), never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/infra_reset_sequencer_if.sv
// Lock/request inputs and staged reset outputs of the reset sequencer.
interface infra_reset_sequencer_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic             pll_lock;
    logic             sw_rst_req;
    logic             cnt_clr;
    logic [N_CH-1:0]  rst_out;
    logic             done;
    logic [CNT_W-1:0] lock_loss_cnt;

    modport master (
        output pll_lock, sw_rst_req, cnt_clr,
        input  rst_out, done, lock_loss_cnt
    );

    modport slave (
        input  pll_lock, sw_rst_req, cnt_clr,
        output rst_out, done, lock_loss_cnt
    );
endinterface

// File: rtl/infra_reset_sequencer_sync_bit.sv
// Multi-stage single-bit synchroniser with asynchronous clear to 0.
module infra_reset_sequencer_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/infra_reset_sequencer.sv
// Staged reset sequencer: holds per-domain resets until lock is stable, then releases them in order.
// state     | meaning
// WAIT_LOCK | all resets held, waiting for synchronised lock
// HOLD      | lock seen, counting the stability hold time
// RELEASE   | releasing one output every STAGE_GAP cycles
// RUN       | all outputs released, done asserted
module infra_reset_sequencer
    import infra_reset_sequencer_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 65536,
    parameter int STAGE_GAP   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input logic                    sys_clk,
    input logic                    sys_rst,
    infra_reset_sequencer_if.slave bus
);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int GAP_W  = cnt_width(STAGE_GAP);
    localparam int STG_W  = cnt_width(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              lock_s;
    seq_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [N_CH-1:0]   rst_q, rst_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  loss_q, loss_d;
    logic              lock_lost, restart, hold_done, gap_done, last_stage;

    infra_reset_sequencer_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (bus.pll_lock),
        .q   (lock_s)
    );

    assign lock_lost  = (state_q != WAIT_LOCK) && !lock_s;
    assign restart    = (state_q != WAIT_LOCK) && bus.sw_rst_req;
    assign hold_done  = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
    assign gap_done   = (gap_q == GAP_W'(STAGE_GAP - 1));
    assign last_stage = (stage_q == STG_W'(N_CH - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
            gap_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            stage_q <= stage_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            loss_q  <= loss_d;
        end
    end

    // Lock loss outranks a software request; both outrank normal sequencing.
    always_comb begin
        state_d = state_q;
        if (lock_lost) begin
            state_d = WAIT_LOCK;
        end else if (restart) begin
            state_d = HOLD;
        end else begin
            case (state_q)
                WAIT_LOCK: if (lock_s) state_d = HOLD;
                HOLD:      if (hold_done) state_d = (N_CH == 1) ? RUN : RELEASE;
                RELEASE:   if (gap_done && last_stage) state_d = RUN;
                RUN:       state_d = RUN;
                default:   state_d = WAIT_LOCK;
            endcase
        end
    end

    always_comb begin
        hold_d  = hold_q;
        gap_d   = gap_q;
        stage_d = stage_q;
        rst_d   = rst_q;
        done_d  = done_q;
        loss_d  = loss_q;

        if (bus.cnt_clr) begin
            loss_d = CNT_W'(lock_lost);
        end else if (lock_lost && (loss_q != CNT_MAX)) begin
            loss_d = loss_q + 1'b1;
        end

        if (lock_lost || restart) begin
            hold_d  = '0;
            gap_d   = '0;
            stage_d = '0;
            rst_d   = '1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: hold_d = '0;
                HOLD: begin
                    if (hold_done) begin
                        rst_d[0] = 1'b0;
                        stage_d  = STG_W'(1);
                        gap_d    = '0;
                        done_d   = (N_CH == 1);
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_done) begin
                        rst_d[stage_q] = 1'b0;
                        gap_d          = '0;
                        stage_d        = stage_q + 1'b1;
                        done_d         = last_stage;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rst_out       = rst_q;
    assign bus.done          = done_q;
    assign bus.lock_loss_cnt = loss_q;
endmodule

// File: tb/tb_infra_reset_sequencer.sv
// Self-checking bench for infra_reset_sequencer against a time-arithmetic reference model.
module tb_infra_reset_sequencer;
    localparam int N_CH  = 3;
    localparam int HOLD  = 8;
    localparam int GAP   = 4;
    localparam int SYNC  = 2;
    localparam int CNT_W = 4;
    localparam int unsigned CNT_MAX = 15;
    localparam int VW = N_CH + 1 + CNT_W;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;

    infra_reset_sequencer_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    infra_reset_sequencer #(
        .N_CH(N_CH), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: whether a sequence is active, the edge it started on, and the loss count.
    typedef struct packed {
        bit          act;
        int unsigned t0;
        int unsigned cnt;
    } mstate_t;

    typedef struct {
        logic lock;
        logic req;
        logic clr;
        int   cycles;
    } phase_t;

    mstate_t         m = '0;
    logic [SYNC-1:0] m_pipe = '0;
    int              m_edge = 0;

    function automatic mstate_t model_step(mstate_t s, logic ls, logic clr, logic req, int unsigned e);
        mstate_t n = s;
        if (s.act && !ls) begin
            n.act = 1'b0;
            n.cnt = clr ? 32'd1 : ((s.cnt < CNT_MAX) ? s.cnt + 32'd1 : CNT_MAX);
        end else begin
            if (clr) n.cnt = 32'd0;
            if (s.act && req) begin
                n.t0 = e;
            end else if (!s.act && ls) begin
                n.act = 1'b1;
                n.t0  = e;
            end
        end
        return n;
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m      <= '0;
            m_pipe <= '0;
        end else begin
            m      <= model_step(m, m_pipe[SYNC-1], bus.cnt_clr, bus.sw_rst_req, m_edge + 1);
            m_pipe <= {m_pipe[SYNC-2:0], bus.pll_lock};
            m_edge <= m_edge + 1;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic [N_CH-1:0] r;
        logic d;
        for (int i = 0; i < N_CH; i++)
            r[i] = !(m.act && (m_edge >= int'(m.t0) + HOLD + i * GAP));
        d = m.act && (m_edge >= int'(m.t0) + HOLD + (N_CH - 1) * GAP);
        return {r, d, CNT_W'(m.cnt)};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {bus.rst_out, bus.done, bus.lock_loss_cnt};
    endfunction

    task automatic drive(input logic lock, input logic req, input logic clr);
        bus.pll_lock   = lock;
        bus.sw_rst_req = req;
        bus.cnt_clr    = clr;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (obs() !== {{N_CH{1'b1}}, 1'b0, {CNT_W{1'b0}}})
            $display("FAIL reset_state: got %b required %b", obs(), {{N_CH{1'b1}}, 1'b0, {CNT_W{1'b0}}});
        if (obs() !== {{N_CH{1'b1}}, 1'b0, {CNT_W{1'b0}}}) miscompares++;
        sys_rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_idle edge %0d: got %b required %b", m_edge, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_lock_rise();
        int e0;
        int fall [N_CH];
        int done_at = -1;
        foreach (fall[i]) fall[i] = -1;
        drive(1'b1, 1'b0, 1'b0);
        e0 = m_edge + 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge sys_clk);
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL lock_rise edge %0d: got %b required %b", m_edge, obs(), exp_vec());
            end
            for (int i = 0; i < N_CH; i++)
                if (fall[i] < 0 && bus.rst_out[i] == 1'b0) fall[i] = m_edge;
            if (done_at < 0 && bus.done) done_at = m_edge;
        end
        for (int i = 0; i < N_CH; i++) begin
            vectors++;
            if (fall[i] != e0 + SYNC + HOLD + i * GAP) begin
                miscompares++;
                $display("FAIL rise_release_%0d: got edge %0d required %0d", i, fall[i], e0 + SYNC + HOLD + i * GAP);
            end
        end
        vectors++;
        if (done_at != e0 + SYNC + HOLD + (N_CH - 1) * GAP || bus.lock_loss_cnt !== '0) begin
            miscompares++;
            $display("FAIL rise_done: got edge %0d cnt %0d required %0d cnt 0", done_at, bus.lock_loss_cnt,
                     e0 + SYNC + HOLD + (N_CH - 1) * GAP);
        end
    endtask

    task automatic test_lock_drop();
        phase_t ph [4] = '{'{1'b0, 1'b0, 1'b0, 4}, '{1'b1, 1'b0, 1'b0, 13},
                           '{1'b0, 1'b0, 1'b0, 6}, '{1'b1, 1'b0, 1'b0, 25}};
        for (int p = 0; p < 4; p++) begin
            drive(ph[p].lock, ph[p].req, ph[p].clr);
            for (int c = 0; c < ph[p].cycles; c++) begin
                @(negedge sys_clk);
                vectors++;
                if (obs() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL lock_drop edge %0d: got %b required %b", m_edge, obs(), exp_vec());
                end
            end
            if (p == 1) begin
                vectors++;
                if (bus.rst_out !== 3'b110) begin
                    miscompares++;
                    $display("FAIL mid_release: got %b required 110", bus.rst_out);
                end
            end
        end
        vectors++;
        if (bus.lock_loss_cnt !== 4'd2 || bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_relock: got cnt %0d done %b required cnt 2 done 1", bus.lock_loss_cnt, bus.done);
        end
    endtask

    task automatic test_sw_req();
        int e0;
        int fall [N_CH];
        foreach (fall[i]) fall[i] = -1;
        drive(1'b1, 1'b1, 1'b0);
        e0 = m_edge + 1;
        @(negedge sys_clk);
        drive(1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.rst_out !== 3'b111 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_all_high: got %b done %b required 111 done 0", bus.rst_out, bus.done);
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge sys_clk);
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sw_req edge %0d: got %b required %b", m_edge, obs(), exp_vec());
            end
            for (int i = 0; i < N_CH; i++)
                if (fall[i] < 0 && bus.rst_out[i] == 1'b0) fall[i] = m_edge;
        end
        for (int i = 0; i < N_CH; i++) begin
            vectors++;
            if (fall[i] != e0 + HOLD + i * GAP) begin
                miscompares++;
                $display("FAIL sw_release_%0d: got edge %0d required %0d", i, fall[i], e0 + HOLD + i * GAP);
            end
        end
    endtask

    task automatic test_sw_and_loss();
        phase_t ph [5] = '{'{1'b0, 1'b0, 1'b0, 2}, '{1'b0, 1'b1, 1'b0, 1}, '{1'b0, 1'b0, 1'b0, 4},
                           '{1'b0, 1'b1, 1'b0, 1}, '{1'b0, 1'b0, 1'b0, 4}};
        for (int p = 0; p < 5; p++) begin
            drive(ph[p].lock, ph[p].req, ph[p].clr);
            for (int c = 0; c < ph[p].cycles; c++) begin
                @(negedge sys_clk);
                vectors++;
                if (obs() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL sw_and_loss edge %0d: got %b required %b", m_edge, obs(), exp_vec());
                end
            end
        end
        vectors++;
        if (obs() !== {3'b111, 1'b0, 4'd3}) begin
            miscompares++;
            $display("FAIL sw_loss_wait: got %b required %b", obs(), {3'b111, 1'b0, 4'd3});
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) begin
            for (int h = 0; h < 2; h++) begin
                drive(h == 0 ? 1'b1 : 1'b0, 1'b0, 1'b0);
                for (int c = 0; c < 4; c++) begin
                    @(negedge sys_clk);
                    vectors++;
                    if (obs() !== exp_vec()) begin
                        miscompares++;
                        $display("FAIL saturate edge %0d: got %b required %b", m_edge, obs(), exp_vec());
                    end
                end
            end
        end
        vectors++;
        if (bus.lock_loss_cnt !== 4'd15) begin
            miscompares++;
            $display("FAIL saturate_15: got %0d required 15", bus.lock_loss_cnt);
        end
        drive(1'b0, 1'b0, 1'b1);
        @(negedge sys_clk);
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.lock_loss_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL clr_alone: got %0d required 0", bus.lock_loss_cnt);
        end
        drive(1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge sys_clk);
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge sys_clk);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge sys_clk);
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if (obs() !== {3'b111, 1'b0, 4'd1} || obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL clr_with_loss: got %b required %b", obs(), {3'b111, 1'b0, 4'd1});
        end
    endtask

    task automatic test_async_reset();
        int e0;
        int fall0 = -1;
        drive(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge sys_clk);
        vectors++;
        if (bus.rst_out !== 3'b111 || obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL pre_async_hold: got %b required %b", obs(), exp_vec());
        end
        #2 sys_rst = 1'b1;
        #1;
        vectors++;
        if (obs() !== {3'b111, 1'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL async_rst_immediate: got %b required %b", obs(), {3'b111, 1'b0, 4'd0});
        end
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        e0 = m_edge + 1;
        for (int c = 0; c < 14; c++) begin
            @(negedge sys_clk);
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL async_restart edge %0d: got %b required %b", m_edge, obs(), exp_vec());
            end
            if (fall0 < 0 && bus.rst_out[0] == 1'b0) fall0 = m_edge;
        end
        vectors++;
        if (fall0 != e0 + SYNC + HOLD) begin
            miscompares++;
            $display("FAIL async_release_0: got edge %0d required %0d", fall0, e0 + SYNC + HOLD);
        end
    endtask

    task automatic test_random();
        logic lock = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (lock) lock = ($urandom_range(0, 39) != 0);
            else      lock = ($urandom_range(0, 2) == 0);
            drive(lock && ($urandom_range(0, 99) != 0), $urandom_range(0, 59) == 0, $urandom_range(0, 119) == 0);
            if (lock && $urandom_range(0, 49) == 0) begin
                #1 bus.pll_lock = 1'b0;
                #1 bus.pll_lock = 1'b1;
            end
            @(negedge sys_clk);
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random edge %0d: got %b required %b", m_edge, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_lock_rise();
        test_lock_drop();
        test_sw_req();
        test_sw_and_loss();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
